// File: rtl/vliw_pkg.sv
// vliw_pkg: bundle geometry constants and slot/field helpers shared by the fetch stage.
package vliw_pkg;
    localparam int BUNDLE_W  = 128;
    localparam int SLOT_W    = 32;
    localparam int NUM_SLOTS = 4;
    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;
    localparam int OP_W      = OP_MSB - OP_LSB + 1;
    localparam int FUNCT_W   = FUNCT_MSB - FUNCT_LSB + 1;

    // k = 1..NUM_SLOTS, slot 1 occupies the most significant bits
    function automatic logic [SLOT_W-1:0] slot(input logic [BUNDLE_W-1:0] b, input int k);
        return b[BUNDLE_W - k*SLOT_W +: SLOT_W];
    endfunction

    function automatic logic [OP_W-1:0] op_of(input logic [BUNDLE_W-1:0] b, input int k);
        return OP_W'(slot(b, k) >> OP_LSB);
    endfunction

    function automatic logic [FUNCT_W-1:0] funct_of(input logic [BUNDLE_W-1:0] b, input int k);
        return FUNCT_W'(slot(b, k) >> FUNCT_LSB);
    endfunction
endpackage

// File: rtl/bundle_skid_fifo.sv
// bundle_skid_fifo: 2-entry skid FIFO holding {bundle, pc} records for the fetch stage.
//   clk, rst : clock, async active-high reset
//   push/din : write din at the tail
//   pop      : drop the head (ignored when empty)
//   flush    : empty the FIFO, takes priority over push/pop
//   occ      : occupancy 0..2; head : head entry; valid : occ != 0
module bundle_skid_fifo #(
    parameter int W = 142
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [1:0]   occ,
    output logic [W-1:0] head,
    output logic         valid
);
    logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0]   occ_q, occ_d, base;
    logic         pop_ok;

    assign pop_ok = pop & (occ_q != 2'd0);
    // slot the pushed entry lands in, after any same-cycle pop has shifted the head
    assign base   = occ_q - {1'b0, pop_ok};

    always_comb begin
        e0_d  = (push && base == 2'd0) ? din : pop_ok ? e1_q : e0_q;
        e1_d  = (push && base == 2'd1) ? din : e1_q;
        occ_d = flush ? 2'd0 : base + {1'b0, push};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0_q  <= '0;
            e1_q  <= '0;
            occ_q <= '0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            occ_q <= occ_d;
        end
    end

    assign occ   = occ_q;
    assign head  = e0_q;
    assign valid = occ_q != 2'd0;

    no_push_when_full: assert property (@(posedge clk) disable iff (rst) push |-> occ_q != 2'd2);
endmodule

// File: rtl/vliw_fetch_buffer.sv
// vliw_fetch_buffer: fetches one bundle per cycle from a 1-cycle synchronous imem and presents the FIFO head with split fields.
//   clk, rst                       : clock, async active-high reset
//   imem_en/imem_addr/imem_rdata   : instruction memory read port (data 1 cycle after en)
//   stall                          : downstream not ready, head held
//   redirect/redirect_pc           : flush and restart fetch at redirect_pc
//   bundle_valid/bundle/bundle_pc  : registered head bundle and its address (zero when empty)
//   op1..op4, funct1, funct2       : opcode of slots 1-4, funct of slots 1-2
module vliw_fetch_buffer
    import vliw_pkg::*;
#(
    parameter int                ADDR_W   = 14,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_en,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [BUNDLE_W-1:0] imem_rdata,
    input  logic                stall,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                bundle_valid,
    output logic [BUNDLE_W-1:0] bundle,
    output logic [ADDR_W-1:0]   bundle_pc,
    output logic [OP_W-1:0]     op1,
    output logic [OP_W-1:0]     op2,
    output logic [OP_W-1:0]     op3,
    output logic [OP_W-1:0]     op4,
    output logic [FUNCT_W-1:0]  funct1,
    output logic [FUNCT_W-1:0]  funct2
);
    logic [ADDR_W-1:0]          pc_q, pc_d, req_pc_q, req_pc_d;
    logic                       req_v_q, req_v_d;
    logic [1:0]                 occ;
    logic [BUNDLE_W+ADDR_W-1:0] head;
    logic                       valid, consume, issue, fire;

    assign consume = valid & ~stall;
    // issue only if the slot that would receive this response is guaranteed free
    assign issue   = ({1'b0, occ} + {2'b0, req_v_q}) < (3'd2 + {2'b0, consume});
    assign fire    = redirect | issue;

    always_comb begin
        imem_addr = redirect ? redirect_pc : pc_q;
        imem_en   = ~rst & fire;
        pc_d      = fire ? imem_addr + ADDR_W'(1) : pc_q;
        req_v_d   = fire;
        req_pc_d  = fire ? imem_addr : req_pc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            req_v_q  <= 1'b0;
            req_pc_q <= '0;
        end else begin
            pc_q     <= pc_d;
            req_v_q  <= req_v_d;
            req_pc_q <= req_pc_d;
        end
    end

    // a redirect discards the response in flight and ignores this cycle's consume
    bundle_skid_fifo #(.W(BUNDLE_W + ADDR_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_v_q & ~redirect),
        .pop   (consume & ~redirect),
        .flush (redirect),
        .din   ({imem_rdata, req_pc_q}),
        .occ   (occ),
        .head  (head),
        .valid (valid)
    );

    always_comb begin
        bundle_valid = valid;
        bundle       = valid ? head[ADDR_W +: BUNDLE_W] : '0;
        bundle_pc    = valid ? head[ADDR_W-1:0] : '0;
        op1          = op_of(bundle, 1);
        op2          = op_of(bundle, 2);
        op3          = op_of(bundle, 3);
        op4          = op_of(bundle, 4);
        funct1       = funct_of(bundle, 1);
        funct2       = funct_of(bundle, 2);
    end
endmodule

// File: doc/vliw_fetch_buffer.md
Name: vliw_fetch_buffer

Overview:
- Instruction-fetch stage for the 4-slot VLIW core. Sits directly upstream of the bundle decoder.
- Drives a synchronous instruction memory one bundle per cycle and buffers returned bundles in a 2-entry skid FIFO.
- Presents the head bundle with its PC and pre-split opcode/funct fields, so the decoder can consume Op1–Op4 and Funct1/Funct2 directly.
- Honours a downstream stall and a branch/jump redirect (flush).

Parameters:
- ADDR_W, 14, bundle-granular instruction address width.
- RESET_PC, 0, first bundle address fetched after reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; asynchronous and active-high.
- imem_en  out  1  read enable to instruction memory.
- imem_addr  out  ADDR_W  bundle address.
- imem_rdata  in  128  bundle returned exactly 1 cycle after an imem_en cycle.
- stall  in  1  downstream not ready; head bundle must be held.
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  ADDR_W  new fetch address.
- bundle_valid  out  1  head entry present.
- bundle  out  128  head bundle. Slot1 = [127:96], slot2 = [95:64], slot3 = [63:32], slot4 = [31:0].
- bundle_pc  out  ADDR_W  address of head bundle.
- op1, op2, op3, op4  out  6 each  bits [31:26] of slots 1–4.
- funct1, funct2  out  6 each  bits [5:0] of slots 1 and 2.

Behaviour:
State:
- pc register.
- In-flight flag req_v plus req_pc.
- FIFO occupancy occ in 0..2.
- Two entries, each holding {bundle, pc}.

Definitions:
- consume = bundle_valid & ~stall.
- issue = (occ + req_v − consume) < 2, evaluated without redirect.

Reset (asynchronous):
- pc = RESET_PC; req_v = 0; occ = 0.
- bundle_valid = 0; bundle, bundle_pc and all field outputs = 0; imem_en = 0 while rst is high.

Normal cycle (no redirect):
- imem_en = issue; imem_addr = pc.
- On issue: pc <= pc+1, wrapping modulo 2^ADDR_W; req_v <= 1; req_pc <= pc. Otherwise req_v <= 0.
- If req_v: imem_rdata and req_pc are pushed into the FIFO tail this cycle.
- If consume: the head is popped.
- Push and pop may occur in the same cycle.
- The issue rule guarantees a push never targets a full FIFO. A push with occ=2 is an assertion failure.

Output timing:
- Outputs come from the registered FIFO head only; there is no bypass of imem_rdata.
- Fetch-to-valid latency is 2 cycles: issue at t, data at t+1, visible at t+2.

Throughput and stall:
- With stall held low, the stage sustains 1 bundle per cycle (steady state occ=1, req_v=1).
- When stall rises, the one in-flight response lands in the second entry. Issue then stops: imem_en=0 until a pop frees space.
- The head bundle and its fields are stable for every cycle stall is high.

Redirect (priority over stall and issue):
- In the redirect cycle: imem_en = 1; imem_addr = redirect_pc.
- Next state: occ = 0; the in-flight response is discarded, not pushed; req_v = 1, req_pc = redirect_pc; pc = redirect_pc+1.
- bundle_valid drops in the cycle after redirect. The target bundle becomes valid 2 cycles after redirect.
- The consume value in the redirect cycle is ignored.
- Back-to-back redirects: the latest one wins; earlier targets never appear.

Empty FIFO:
- bundle_valid = 0 and bundle/fields/bundle_pc = 0. An all-zero word decodes as a harmless R-type to r0.

Reset mid-operation:
- Immediate return to reset state. Any memory response pending at reset release is ignored.

Decomposition:
- Shared package vliw_pkg holds:
  - BUNDLE_W = 128, SLOT_W = 32, NUM_SLOTS = 4.
  - OP_MSB = 31, OP_LSB = 26, FUNCT_MSB = 5, FUNCT_LSB = 0.
  - A function slot(bundle, k) returning the k-th 32-bit slot (k = 1..4, slot 1 at the MSBs).
- One sub-module, bundle_skid_fifo: 2-entry, width BUNDLE_W + ADDR_W, with push, pop and flush inputs, and occ, head and valid outputs.
- Fetch control (pc, req_v, issue) and field extraction stay in vliw_fetch_buffer.

Test Plan:
1. Reset release, RESET_PC = 0, memory word at address n = {4{n}} -> imem_addr 0, 1, 2… on consecutive cycles; bundle_valid first high 2 cycles after release with bundle_pc = 0; then bundle_pc increments by 1 every cycle.
2. Stall held 3 cycles while head pc = 5 -> head stays pc 5; FIFO fills with pc 6; imem_en low for the remaining stall cycles; after stall drops, pcs 5, 6, 7… in order, none lost or duplicated.
3. Redirect to 0x100 while head pc = 9 and pc 10 is in flight -> pc 10 never presented; bundle_valid low for 1 cycle; then pc 0x100, 0x101…
4. Redirect asserted in the same cycle as stall, with the FIFO full -> flush wins; target bundle appears 2 cycles later.
5. Slot encoding, slot1 = 0x0400_0022, slot2 = 0x2C00_0020, slot3 = 0x1800_0000, slot4 = 0x1C00_0000 -> op1 = 0x01, funct1 = 0x22, op2 = 0x0B, funct2 = 0x20, op3 = 0x06, op4 = 0x07.
6. Redirect to 2^ADDR_W−1 -> next fetch address 0 (wrap); also assert rst mid-stream -> bundle_valid is 0 immediately and fetch restarts at RESET_PC.
